skewed_lane_feeder: RTL and testbench
=====================================

// Module: skewed_lane_feeder
// PURPOSE
//  Multi-lane operand feeder for the systolic MAC array. Accepts one packed burst of
//  LANES x DEPTH elements through a valid/ready load handshake, then emits one element
//  per lane per enabled step, with lane i delayed by i steps (diagonal wavefront).
//  Inactive lane slots read zero. Sits between the operand buffer and the array edge PEs.
// PARAMETERS
//  DATA_W  8  element width in bits (>=1)
//  DEPTH   7  elements per lane per burst (>=1)
//  LANES   4  number of output lanes, i.e. array rows/cols fed (>=1)
// PORTS
//  clk         in   1                   rising-edge clock
//  reset       in   1                   synchronous, active-high reset
//  load_valid  in   1                   burst on load_data is offered
//  load_ready  out  1                   feeder idle, can accept a burst
//  load_data   in   LANES*DEPTH*DATA_W  packed burst; lane i = [i*DEPTH*DATA_W +: DEPTH*DATA_W]
//  enable      in   1                   advance one wavefront step
//  data_out    out  LANES*DATA_W        lane i element at [i*DATA_W +: DATA_W]
//  lane_valid  out  LANES               per-lane qualifier for data_out
//  busy        out  1                   burst loaded and not yet fully emitted
//  done        out  1                   one-cycle pulse after final step
// BEHAVIOUR
//  - Reset (sync, high): state IDLE, step=0, burst reg=0, data_out=0, lane_valid=0, done=0.
//    Reset mid-stream aborts the burst; no done pulse; load_ready=1 the cycle after.
//  - Element order: element 0 of each lane = MOST-significant DATA_W bits of its lane slice.
//  - States: IDLE, STREAM. load_ready = (state==IDLE); busy = (state==STREAM). Combinational.
//  - IDLE: on edge with load_valid&load_ready -> latch load_data, step=0, go STREAM.
//    load_data not sampled otherwise. enable in IDLE ignored.
//  - STREAM: on edge with enable=1, for each lane i with j=step-i:
//    0<=j<DEPTH -> data_out[i]=element j, lane_valid[i]=1; else data_out[i]=0, lane_valid[i]=0.
//    step increments. Total steps S = DEPTH+LANES-1; counter width $clog2(S+1).
//  - Edge with enable=0 (any state): data_out holds, lane_valid=0 (valid is a 1-cycle pulse).
//  - Final step (step==S-1 with enable): outputs as above, state->IDLE, done=1 for the next
//    cycle only (coincides with last lane_valid pulse). load_valid seen in that done cycle
//    is accepted (back-to-back bursts, no bubble beyond the handshake cycle).
//  - load_valid while busy: ignored, no back-pressure side effects, burst reg unchanged.
//  - Latency: load edge -> first data on the first subsequent enable edge; registered outputs.
//  - LANES=1 degenerates to plain byte-serial feeder (no skew, S=DEPTH).
// TESTING
//  1. LANES=1,DEPTH=7: load 56'h11223344556677, 7 enables -> data_out 11,22,..,77; done after 7th.
//  2. LANES=2,DEPTH=3: load 48'h112233_AABBCC, 4 enables -> (l1,l0)=(00,AA)v=01,(11,BB)v=11,
//     (22,CC)v=11,(33,00)v=10; done pulse after 4th; load_ready=1 in done cycle.
//  3. Same as 2 with enable gaps (1,0,0,1,1,0,1): outputs hold, lane_valid=0 on gap cycles,
//     sequence identical to 2; busy stays 1 until final step.
//  4. load_valid with new data while busy -> load_ready=0, stream continues with original burst.
//  5. Reset asserted after 2nd step -> next cycle data_out=0, lane_valid=0, load_ready=1, no done.
//  6. Back-to-back: 2nd burst 48'hA1B2C3_D4E5F6 offered during done cycle -> accepted,
//     next 4 enables emit (00,D4),(A1,E5),(B2,F6),(C3,00).

Source files
------------

// File: rtl/skewed_lane_feeder_if.sv
// Load/stream bundle for the skewed lane feeder: burst handshake in,
// per-lane wavefront data and status out.
interface skewed_lane_feeder_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int LANES  = 4
) ();
  logic                          load_valid;
  logic                          load_ready;
  logic [LANES*DEPTH*DATA_W-1:0] load_data;
  logic                          enable;
  logic [LANES*DATA_W-1:0]       data_out;
  logic [LANES-1:0]              lane_valid;
  logic                          busy;
  logic                          done;

  modport master (
    output load_valid, load_data, enable,
    input  load_ready, data_out, lane_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, enable,
    output load_ready, data_out, lane_valid, busy, done
  );
endinterface

// File: rtl/skewed_lane_feeder.sv
// Skewed multi-lane operand feeder: latches one burst, then streams it as a
// diagonal wavefront with lane i lagging lane 0 by i enabled steps.
module skewed_lane_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  skewed_lane_feeder_if.slave bus
);
  localparam int STEPS   = DEPTH + LANES - 1;
  localparam int STEP_W  = $clog2(STEPS + 1);
  localparam int BURST_W = LANES * DEPTH * DATA_W;
  localparam int OUT_W   = LANES * DATA_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STEP_W-1:0]  r_step;
  logic [BURST_W-1:0] r_burst;
  logic [OUT_W-1:0]   r_data_out;
  logic [OUT_W-1:0]   w_data_nxt;
  logic [LANES-1:0]   r_lane_valid;
  logic [LANES-1:0]   w_valid_nxt;
  logic               r_done;
  logic               w_load;
  logic               w_fire;
  logic               w_last;

  assign w_load = (r_state == ST_IDLE) && bus.load_valid;
  assign w_fire = (r_state == ST_STREAM) && bus.enable;
  assign w_last = w_fire && (r_step == STEP_W'(STEPS - 1));

  // Wavefront slice for the current step; element 0 sits in the top bits of a lane slice.
  always_comb begin
    w_data_nxt  = '0;
    w_valid_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w_data_nxt[i*DATA_W +: DATA_W] = w_data_nxt[i*DATA_W +: DATA_W] |
          ((int'(r_step) == i + j) ? r_burst[(i*DEPTH + DEPTH - 1 - j)*DATA_W +: DATA_W]
                                   : {DATA_W{1'b0}});
        w_valid_nxt[i] = w_valid_nxt[i] | (int'(r_step) == i + j);
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_STREAM;
        else        w_state_nxt = ST_IDLE;
      end
      ST_STREAM: begin
        if (w_last) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, step counter, burst register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_step       <= '0;
      r_burst      <= '0;
      r_data_out   <= '0;
      r_lane_valid <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_load) begin
        r_burst <= bus.load_data;
        r_step  <= '0;
      end else if (w_fire) begin
        r_step <= w_last ? '0 : r_step + STEP_W'(1);
      end
      // Data holds between enabled steps; valid is a single-cycle pulse.
      if (w_fire) begin
        r_data_out   <= w_data_nxt;
        r_lane_valid <= w_valid_nxt;
      end else begin
        r_lane_valid <= '0;
      end
    end
  end

  assign bus.load_ready = (r_state == ST_IDLE);
  assign bus.busy       = (r_state == ST_STREAM);
  assign bus.data_out   = r_data_out;
  assign bus.lane_valid = r_lane_valid;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_skewed_lane_feeder.sv
// Bench for skewed_lane_feeder: directed vectors on 1x7 and 2x3 feeders,
// randomized 4x7 stream against a behavioural model.
module tb_skewed_lane_feeder;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  skewed_lane_feeder_if #(.DATA_W(8), .DEPTH(7), .LANES(1)) if1 ();
  skewed_lane_feeder_if #(.DATA_W(8), .DEPTH(3), .LANES(2)) if2 ();
  skewed_lane_feeder_if #(.DATA_W(8), .DEPTH(7), .LANES(4)) if3 ();

  skewed_lane_feeder #(.DATA_W(8), .DEPTH(7), .LANES(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  skewed_lane_feeder #(.DATA_W(8), .DEPTH(3), .LANES(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
  skewed_lane_feeder #(.DATA_W(8), .DEPTH(7), .LANES(4)) u3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct packed {
    logic        lv;
    logic        en;
    logic [47:0] ld;
    logic [15:0] dout;
    logic [1:0]  vld;
    logic        done;
    logic        rdy;
    logic        bsy;
  } vec_t;

  vec_t tbl [19];

  // behavioural model state for the 4x7 instance
  logic [7:0]  m_el [4][7];
  int          m_step;
  bit          m_stream;
  logic [31:0] m_dout;
  logic [3:0]  m_vld;
  bit          m_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_u2(input string name, input logic [15:0] dout, input logic [1:0] vld,
                          input logic done, input logic rdy, input logic bsy);
    check({name, ".data"},  64'(if2.data_out),   64'(dout));
    check({name, ".valid"}, 64'(if2.lane_valid), 64'(vld));
    check({name, ".done"},  64'(if2.done),       64'(done));
    check({name, ".ready"}, 64'(if2.load_ready), 64'(rdy));
    check({name, ".busy"},  64'(if2.busy),       64'(bsy));
  endtask

  task automatic model_step(input logic lv, input logic en, input logic [223:0] ld);
    int j;
    m_done = 1'b0;
    if (!m_stream) begin
      m_vld = 4'b0000;
      if (lv) begin
        for (int i = 0; i < 4; i++)
          for (int k = 0; k < 7; k++)
            m_el[i][k] = ld[(i*7 + 6 - k)*8 +: 8];
        m_step   = 0;
        m_stream = 1'b1;
      end
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        j = m_step - i;
        if (j >= 0 && j < 7) begin
          m_dout[i*8 +: 8] = m_el[i][j];
          m_vld[i]         = 1'b1;
        end else begin
          m_dout[i*8 +: 8] = 8'h00;
          m_vld[i]         = 1'b0;
        end
      end
      m_step++;
      if (m_step == 10) begin
        m_stream = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      m_vld = 4'b0000;
    end
  endtask

  initial begin
    logic [223:0] rld;
    logic         rlv;
    logic         ren;

    // u2 vectors: burst 1, back-to-back burst 2 with enable gaps, ignored load while busy
    tbl[0]  = '{1'b1, 1'b0, 48'h112233AABBCC, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 48'h0,            16'h00AA, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 48'h0,            16'h11BB, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 48'h0,            16'h22CC, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 48'h0,            16'h3300, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 48'hA1B2C3D4E5F6, 16'h3300, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 48'h0,            16'h00D4, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 48'h0,            16'h00D4, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 48'h0,            16'h00D4, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 48'h0,            16'hA1E5, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 48'h0,            16'hB2F6, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 48'h0,            16'hB2F6, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 48'h0,            16'hC300, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 48'h112233AABBCC, 16'hC300, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 48'hFFFFFFFFFFFF, 16'h00AA, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 48'hFFFFFFFFFFFF, 16'h11BB, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 48'h0,            16'h22CC, 2'b11, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 48'h0,            16'h3300, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 48'h0,            16'h3300, 2'b00, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    if1.load_valid = 1'b0; if1.enable = 1'b0; if1.load_data = '0;
    if2.load_valid = 1'b0; if2.enable = 1'b0; if2.load_data = '0;
    if3.load_valid = 1'b0; if3.enable = 1'b0; if3.load_data = '0;
    m_step = 0; m_stream = 1'b0; m_dout = '0; m_vld = '0; m_done = 1'b0;
    tick();
    tick();
    check_u2("reset", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // LANES=1 byte-serial feeder
    if1.load_valid = 1'b1;
    if1.load_data  = 56'h11223344556677;
    tick();
    if1.load_valid = 1'b0;
    check("l1.busy", 64'(if1.busy), 64'd1);
    for (int k = 0; k < 7; k++) begin
      logic [7:0] e;
      e = 8'((k + 1) * 17);
      if1.enable = 1'b1;
      tick();
      check("l1.data",  64'(if1.data_out),   64'(e));
      check("l1.valid", 64'(if1.lane_valid), 64'd1);
      check("l1.done",  64'(if1.done),       64'(k == 6));
    end
    if1.enable = 1'b0;
    tick();
    check("l1.done_clear",  64'(if1.done),       64'd0);
    check("l1.valid_clear", 64'(if1.lane_valid), 64'd0);
    check("l1.ready",       64'(if1.load_ready), 64'd1);

    // LANES=2 table
    for (int v = 0; v < 19; v++) begin
      if2.load_valid = tbl[v].lv;
      if2.enable     = tbl[v].en;
      if2.load_data  = tbl[v].ld;
      tick();
      check_u2($sformatf("vec%0d", v), tbl[v].dout, tbl[v].vld, tbl[v].done, tbl[v].rdy,
               tbl[v].bsy);
    end

    // reset after the second step aborts the burst without a done pulse
    if2.load_valid = 1'b1; if2.enable = 1'b0; if2.load_data = 48'h112233AABBCC;
    tick();
    if2.load_valid = 1'b0; if2.enable = 1'b1;
    tick();
    tick();
    check_u2("pre_reset", 16'h11BB, 2'b11, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    check_u2("mid_reset", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    check_u2("post_reset", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
    if2.enable = 1'b0;

    // randomized 4x7 stream against the model
    for (int c = 0; c < 800; c++) begin
      rlv = ($urandom_range(0, 3) == 0);
      ren = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 7; k++) rld[k*32 +: 32] = $urandom;
      if3.load_valid = rlv;
      if3.enable     = ren;
      if3.load_data  = rld;
      model_step(rlv, ren, rld);
      tick();
      check($sformatf("rand%0d", c),
            64'({if3.data_out, if3.lane_valid, if3.done, if3.load_ready, if3.busy}),
            64'({m_dout, m_vld, m_done, !m_stream, m_stream}));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
